// File: rtl/icache_plru_arbiter_if.sv
// Bundle between the icache pipe, the PLRU port arbiter and the icache_plru state array.
interface icache_plru_arbiter_if #(
    parameter int unsigned INDEX_W = 6,
    parameter int unsigned WAY_W   = 3
);
    // hit-way update request from hit_read
    logic               hit_valid;
    logic [INDEX_W-1:0] hit_index;
    logic [WAY_W-1:0]   hit_way;
    logic               hit_ready;

    // victim lookup request / response with replace
    logic               rep_req_valid;
    logic [INDEX_W-1:0] rep_req_index;
    logic               rep_req_ready;
    logic               rep_rsp_valid;
    logic [WAY_W-1:0]   rep_rsp_way;
    logic               rep_rsp_ready;

    // single port of the PLRU state array
    logic               plru_hit_valid;
    logic [INDEX_W-1:0] plru_hit_index;
    logic [WAY_W-1:0]   plru_hit_way;
    logic               plru_rep_valid;
    logic [INDEX_W-1:0] plru_rep_index;
    logic               plru_rep_ready;
    logic [WAY_W-1:0]   plru_way;

    // surroundings: icache pipe plus the PLRU array
    modport master (
        output hit_valid, hit_index, hit_way,
        input  hit_ready,
        output rep_req_valid, rep_req_index,
        input  rep_req_ready,
        input  rep_rsp_valid, rep_rsp_way,
        output rep_rsp_ready,
        input  plru_hit_valid, plru_hit_index, plru_hit_way,
        input  plru_rep_valid, plru_rep_index, plru_rep_ready,
        output plru_way
    );

    // the arbiter itself
    modport slave (
        input  hit_valid, hit_index, hit_way,
        output hit_ready,
        input  rep_req_valid, rep_req_index,
        output rep_req_ready,
        output rep_rsp_valid, rep_rsp_way,
        input  rep_rsp_ready,
        output plru_hit_valid, plru_hit_index, plru_hit_way,
        output plru_rep_valid, plru_rep_index, plru_rep_ready,
        input  plru_way
    );
endinterface

// File: rtl/icache_plru_arbiter.sv
// Shares the single icache PLRU port between queued hit updates (writes) and
// victim lookups (reads). A lookup waits until every update to its set that
// was queued when it was accepted has been written.
module icache_plru_arbiter #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned INDEX_W    = 6,
    parameter int unsigned WAY_W      = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    icache_plru_arbiter_if.slave bus
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_RESP   = 2'd2
    } state_e;

    state_e             state_q, state_d;

    logic [INDEX_W-1:0] idx_q [FIFO_DEPTH];
    logic [WAY_W-1:0]   way_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [FIFO_DEPTH-1:0] haz_q, haz_d;
    logic [INDEX_W-1:0] req_index_q, req_index_d;
    logic [WAY_W-1:0]   rsp_way_q, rsp_way_d;

    logic                  fifo_empty_c;
    logic                  fifo_full_c;
    logic                  hazard_c;
    logic                  grant_c;
    logic                  pop_c;
    logic                  push_c;
    logic                  accept_c;
    logic                  hit_ready_c;
    logic                  rep_req_ready_c;
    logic                  rep_rsp_valid_c;
    logic [PTR_W-1:0]      slot_off_c [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] slot_vld_c;

    // FIFO status and port arbitration
    always_comb begin
        fifo_empty_c = (count_q == '0);
        fifo_full_c  = (count_q == CNT_W'(FIFO_DEPTH));
        hazard_c     = |haz_q;
        hit_ready_c  = !fifo_full_c && !flush_i;
        push_c       = bus.hit_valid && hit_ready_c;
        accept_c     = bus.rep_req_valid && rep_req_ready_c;
        pop_c        = !fifo_empty_c && !grant_c && !flush_i;
    end

    // occupied-slot map, used to snapshot the hazard set at lookup accept
    always_comb begin
        slot_vld_c = '0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            slot_off_c[i] = PTR_W'(i) - rd_ptr_q;
            slot_vld_c[i] = ({1'b0, slot_off_c[i]} < count_q);
        end
    end

    // FIFO pointer / occupancy next state; flush empties the queue
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // hazard mask: older same-set entries captured at accept, cleared as they pop
    always_comb begin
        haz_d = haz_q;
        if (flush_i) begin
            haz_d = '0;
        end else if (accept_c) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                haz_d[i] = slot_vld_c[i] && (idx_q[i] == bus.rep_req_index)
                           && !(pop_c && (rd_ptr_q == PTR_W'(i)));
            end
        end else if (pop_c) begin
            haz_d[rd_ptr_q] = 1'b0;
        end
    end

    // lookup index latch and victim capture
    always_comb begin
        req_index_d = req_index_q;
        rsp_way_d   = rsp_way_q;
        if (accept_c) begin
            req_index_d = bus.rep_req_index;
        end
        if (grant_c) begin
            rsp_way_d = bus.plru_way;
        end
    end

    // queue storage
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                idx_q[i] <= '0;
                way_q[i] <= '0;
            end
        end else if (push_c) begin
            idx_q[wr_ptr_q] <= bus.hit_index;
            way_q[wr_ptr_q] <= bus.hit_way;
        end
    end

    // datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            haz_q       <= '0;
            req_index_q <= '0;
            rsp_way_q   <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            haz_q       <= haz_d;
            req_index_q <= req_index_d;
            rsp_way_q   <= rsp_way_d;
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; flush always returns to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept_c)          state_d = S_LOOKUP;
            S_LOOKUP: if (grant_c)           state_d = S_RESP;
            S_RESP:   if (bus.rep_rsp_ready) state_d = S_IDLE;
            default:                         state_d = S_IDLE;
        endcase
        if (flush_i) begin
            state_d = S_IDLE;
        end
    end

    // FSM outputs; the read is granted only once the hazard set has drained
    always_comb begin
        rep_req_ready_c = 1'b0;
        rep_rsp_valid_c = 1'b0;
        grant_c         = 1'b0;
        case (state_q)
            S_IDLE:   rep_req_ready_c = !flush_i;
            S_LOOKUP: grant_c         = !hazard_c && !flush_i;
            S_RESP:   rep_rsp_valid_c = 1'b1;
            default:  ;
        endcase
    end

    // bus drive; RAM address/data held at zero when the port is unused
    assign bus.hit_ready      = hit_ready_c;
    assign bus.rep_req_ready  = rep_req_ready_c;
    assign bus.rep_rsp_valid  = rep_rsp_valid_c;
    assign bus.rep_rsp_way    = rsp_way_q;
    assign bus.plru_hit_valid = pop_c;
    assign bus.plru_hit_index = pop_c ? idx_q[rd_ptr_q] : '0;
    assign bus.plru_hit_way   = pop_c ? way_q[rd_ptr_q] : '0;
    assign bus.plru_rep_valid = grant_c;
    assign bus.plru_rep_ready = grant_c;
    assign bus.plru_rep_index = grant_c ? req_index_q : '0;

endmodule

// File: tb/tb_icache_plru_arbiter.sv
// Directed bench for icache_plru_arbiter with a behavioural tree-PLRU array model.
module tb_icache_plru_arbiter;

    localparam int unsigned INDEX_W = 6;
    localparam int unsigned WAY_W   = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    icache_plru_arbiter_if #(.INDEX_W(INDEX_W), .WAY_W(WAY_W)) bus ();

    icache_plru_arbiter #(
        .FIFO_DEPTH (4),
        .INDEX_W    (INDEX_W),
        .WAY_W      (WAY_W)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (flush),
        .bus     (bus.slave)
    );

    // Tree PLRU, 8 ways: t[0] root, t[1..2] halves, t[3..6] pairs.
    // A node bit names the side holding the victim (0 = lower ways);
    // a touch points every node on the path away from the touched way.
    function automatic logic [6:0] plru_touch(input logic [6:0] t, input logic [2:0] w);
        logic [6:0] r;
        r = t;
        r[0] = ~w[2];
        r[1 + int'(w[2])] = ~w[1];
        r[3 + int'(w[2:1])] = ~w[0];
        return r;
    endfunction

    function automatic logic [2:0] plru_victim(input logic [6:0] t);
        logic v2, v1, v0;
        v2 = t[0];
        v1 = t[1 + int'(v2)];
        v0 = t[3 + int'({v2, v1})];
        return {v2, v1, v0};
    endfunction

    logic [6:0] tree [64];
    logic [8:0] wr_log [$];
    int         rd_cnt   = 0;
    int         both_cnt = 0;

    initial begin
        for (int i = 0; i < 64; i++) tree[i] = '0;
    end

    // PLRU array model: write on hit port, record every access
    always @(posedge clk) begin
        if (bus.plru_hit_valid) begin
            tree[bus.plru_hit_index] <= plru_touch(tree[bus.plru_hit_index], bus.plru_hit_way);
            wr_log.push_back({bus.plru_hit_index, bus.plru_hit_way});
        end
        if (bus.plru_rep_valid) rd_cnt <= rd_cnt + 1;
    end

    assign bus.plru_way = plru_victim(tree[bus.plru_rep_index]);

    // the port must never carry a write and a read together
    always @(negedge clk) begin
        if (bus.plru_hit_valid && bus.plru_rep_valid) both_cnt <= both_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.hit_valid     = 1'b0;
        bus.hit_index     = '0;
        bus.hit_way       = '0;
        bus.rep_req_valid = 1'b0;
        bus.rep_req_index = '0;
        bus.rep_rsp_ready = 1'b0;
        flush             = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (bus.hit_ready !== 1'b1) $display("FAIL reset_hit_ready: got %b expected 1", bus.hit_ready);
        else n_pass++;
        n_checks++;
        if (bus.rep_req_ready !== 1'b1) $display("FAIL reset_rep_req_ready: got %b expected 1", bus.rep_req_ready);
        else n_pass++;
        n_checks++;
        if ({bus.plru_hit_valid, bus.plru_rep_valid, bus.plru_rep_ready} !== 3'b000)
            $display("FAIL reset_plru_valids: got %b expected 000",
                     {bus.plru_hit_valid, bus.plru_rep_valid, bus.plru_rep_ready});
        else n_pass++;
        n_checks++;
        if ({bus.rep_rsp_valid, bus.rep_rsp_way} !== 4'b0000)
            $display("FAIL reset_rsp: got %b expected 0000", {bus.rep_rsp_valid, bus.rep_rsp_way});
        else n_pass++;
    endtask

    task automatic test_hit();
        tick();
        bus.hit_valid = 1'b1;
        bus.hit_index = 6'd5;
        bus.hit_way   = 3'd3;
        #1;
        n_checks++;
        if (bus.hit_ready !== 1'b1) $display("FAIL hit_accept: got %b expected 1", bus.hit_ready);
        else n_pass++;
        n_checks++;
        if (bus.plru_hit_valid !== 1'b0) $display("FAIL hit_no_bypass: got %b expected 0", bus.plru_hit_valid);
        else n_pass++;
        tick();
        bus.hit_valid = 1'b0;
        #1;
        n_checks++;
        if ({bus.plru_hit_valid, bus.plru_hit_index, bus.plru_hit_way} !== {1'b1, 6'd5, 3'd3})
            $display("FAIL hit_write: got v=%b idx=%0d way=%0d expected v=1 idx=5 way=3",
                     bus.plru_hit_valid, bus.plru_hit_index, bus.plru_hit_way);
        else n_pass++;
        tick();
        #1;
        n_checks++;
        if (bus.plru_hit_valid !== 1'b0) $display("FAIL hit_drained: got %b expected 0", bus.plru_hit_valid);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int base;
        int rd0;
        base = wr_log.size();
        rd0  = rd_cnt;
        bus.rep_rsp_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            tick();
            bus.hit_valid     = (c < 5);
            bus.hit_index     = INDEX_W'(10 + c);
            bus.hit_way       = WAY_W'(c);
            bus.rep_req_valid = (c == 0);
            bus.rep_req_index = 6'd9;
            #1;
            if (c < 5) begin
                n_checks++;
                if (bus.hit_ready !== 1'b1) $display("FAIL b2b_hit_ready[%0d]: got %b expected 1", c, bus.hit_ready);
                else n_pass++;
            end
            if (c == 0) begin
                n_checks++;
                if (bus.rep_req_ready !== 1'b1) $display("FAIL b2b_req_ready: got %b expected 1", bus.rep_req_ready);
                else n_pass++;
            end
            if (c == 1) begin
                n_checks++;
                if ({bus.plru_rep_valid, bus.plru_rep_ready, bus.plru_rep_index, bus.plru_hit_valid}
                    !== {1'b1, 1'b1, 6'd9, 1'b0})
                    $display("FAIL b2b_read_grant: got rv=%b rr=%b idx=%0d hv=%b expected 1 1 9 0",
                             bus.plru_rep_valid, bus.plru_rep_ready, bus.plru_rep_index, bus.plru_hit_valid);
                else n_pass++;
            end
            if (c == 2) begin
                n_checks++;
                if ({bus.rep_rsp_valid, bus.rep_rsp_way} !== {1'b1, 3'd0})
                    $display("FAIL b2b_rsp: got v=%b way=%0d expected v=1 way=0", bus.rep_rsp_valid, bus.rep_rsp_way);
                else n_pass++;
            end
        end
        idle_inputs();
        n_checks++;
        if (wr_log.size() - base !== 5) $display("FAIL b2b_write_count: got %0d expected 5", wr_log.size() - base);
        else n_pass++;
        for (int k = 0; k < 5; k++) begin
            if (base + k < wr_log.size()) begin
                n_checks++;
                if (wr_log[base + k] !== {INDEX_W'(10 + k), WAY_W'(k)})
                    $display("FAIL b2b_write_order[%0d]: got %h expected %h", k, wr_log[base + k],
                             {INDEX_W'(10 + k), WAY_W'(k)});
                else n_pass++;
            end
        end
        n_checks++;
        if (rd_cnt - rd0 !== 1) $display("FAIL b2b_read_count: got %0d expected 1", rd_cnt - rd0);
        else n_pass++;
    endtask

    // Builds two queued idx7 entries, then a lookup to idx7 that must wait for them.
    // Victim after touching way1 then way6 from a clear tree: root->0, t[1]->1, t[4]->0 => way 2.
    task automatic test_hazard();
        bus.rep_rsp_ready = 1'b1;
        tick();                                   // T0: lookup idx0, queue X
        bus.rep_req_valid = 1'b1; bus.rep_req_index = 6'd0;
        bus.hit_valid = 1'b1; bus.hit_index = 6'd0; bus.hit_way = 3'd0;
        tick();                                   // T1: read granted, queue A
        bus.rep_req_valid = 1'b0;
        bus.hit_index = 6'd7; bus.hit_way = 3'd1;
        tick();                                   // T2: RESP, queue B
        bus.hit_index = 6'd7; bus.hit_way = 3'd6;
        tick();                                   // T3: IDLE with A,B queued; lookup idx7
        bus.hit_valid = 1'b0;
        bus.rep_req_valid = 1'b1; bus.rep_req_index = 6'd7;
        #1;
        n_checks++;
        if ({bus.rep_req_ready, bus.plru_hit_valid, bus.plru_hit_index, bus.plru_hit_way}
            !== {1'b1, 1'b1, 6'd7, 3'd1})
            $display("FAIL haz_accept: got rr=%b hv=%b idx=%0d way=%0d expected 1 1 7 1",
                     bus.rep_req_ready, bus.plru_hit_valid, bus.plru_hit_index, bus.plru_hit_way);
        else n_pass++;
        tick();                                   // T4: hazard on B, write B
        bus.rep_req_valid = 1'b0;
        #1;
        n_checks++;
        if ({bus.plru_rep_valid, bus.plru_hit_valid, bus.plru_hit_index, bus.plru_hit_way}
            !== {1'b0, 1'b1, 6'd7, 3'd6})
            $display("FAIL haz_wait: got rv=%b hv=%b idx=%0d way=%0d expected 0 1 7 6",
                     bus.plru_rep_valid, bus.plru_hit_valid, bus.plru_hit_index, bus.plru_hit_way);
        else n_pass++;
        tick();                                   // T5: read
        #1;
        n_checks++;
        if ({bus.plru_rep_valid, bus.plru_rep_index, bus.plru_hit_valid} !== {1'b1, 6'd7, 1'b0})
            $display("FAIL haz_read: got rv=%b idx=%0d hv=%b expected 1 7 0",
                     bus.plru_rep_valid, bus.plru_rep_index, bus.plru_hit_valid);
        else n_pass++;
        tick();                                   // T6: response
        #1;
        n_checks++;
        if ({bus.rep_rsp_valid, bus.rep_rsp_way} !== {1'b1, 3'b010})
            $display("FAIL haz_victim: got v=%b way=%b expected v=1 way=010", bus.rep_rsp_valid, bus.rep_rsp_way);
        else n_pass++;
        tick();
        #1;
        n_checks++;
        if (bus.rep_req_ready !== 1'b1) $display("FAIL haz_back_idle: got %b expected 1", bus.rep_req_ready);
        else n_pass++;
        idle_inputs();
    endtask

    // Touching way0 of idx20 leaves victim way 4 (root->1, t[2]->0, t[5]->0).
    task automatic test_resp_hold();
        int base;
        tick();
        bus.hit_valid = 1'b1; bus.hit_index = 6'd20; bus.hit_way = 3'd0;
        tick();
        bus.hit_valid = 1'b0;
        tick();
        bus.rep_req_valid = 1'b1; bus.rep_req_index = 6'd20; bus.rep_rsp_ready = 1'b0;
        tick();                                   // LOOKUP, read granted
        bus.rep_req_valid = 1'b0;
        bus.hit_valid = 1'b1; bus.hit_index = 6'd21; bus.hit_way = 3'd2;
        base = wr_log.size();
        #1;
        n_checks++;
        if (bus.plru_rep_valid !== 1'b1) $display("FAIL hold_read: got %b expected 1", bus.plru_rep_valid);
        else n_pass++;
        for (int c = 0; c < 5; c++) begin
            tick();
            bus.hit_valid = (c == 0);
            bus.hit_index = 6'd22; bus.hit_way = 3'd3;
            #1;
            n_checks++;
            if ({bus.rep_rsp_valid, bus.rep_rsp_way} !== {1'b1, 3'd4})
                $display("FAIL hold_stable[%0d]: got v=%b way=%0d expected v=1 way=4", c,
                         bus.rep_rsp_valid, bus.rep_rsp_way);
            else n_pass++;
        end
        tick();
        bus.rep_rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.rep_rsp_valid !== 1'b1) $display("FAIL hold_last: got %b expected 1", bus.rep_rsp_valid);
        else n_pass++;
        tick();
        bus.rep_rsp_ready = 1'b0;
        #1;
        n_checks++;
        if ({bus.rep_req_ready, bus.rep_rsp_valid} !== 2'b10)
            $display("FAIL hold_idle: got rr=%b v=%b expected 1 0", bus.rep_req_ready, bus.rep_rsp_valid);
        else n_pass++;
        n_checks++;
        if (wr_log.size() - base !== 2) $display("FAIL hold_drain_count: got %0d expected 2", wr_log.size() - base);
        else n_pass++;
        if (wr_log.size() - base == 2) begin
            n_checks++;
            if ({wr_log[base], wr_log[base + 1]} !== {6'd21, 3'd2, 6'd22, 3'd3})
                $display("FAIL hold_drain_order: got %h %h expected %h %h", wr_log[base], wr_log[base + 1],
                         {6'd21, 3'd2}, {6'd22, 3'd3});
            else n_pass++;
        end
        idle_inputs();
    endtask

    task automatic test_flush();
        int wr0;
        int rd0;
        bus.rep_rsp_ready = 1'b1;
        tick();                                   // T0
        bus.rep_req_valid = 1'b1; bus.rep_req_index = 6'd1;
        bus.hit_valid = 1'b1; bus.hit_index = 6'd31; bus.hit_way = 3'd0;
        tick();                                   // T1
        bus.rep_req_valid = 1'b0;
        bus.hit_index = 6'd30; bus.hit_way = 3'd1;
        tick();                                   // T2
        bus.hit_way = 3'd2;
        tick();                                   // T3: lookup idx30, queue younger C
        bus.rep_req_valid = 1'b1; bus.rep_req_index = 6'd30;
        bus.hit_way = 3'd3;
        tick();                                   // T4: LOOKUP waiting, flush
        bus.rep_req_valid = 1'b1;
        bus.hit_way = 3'd4;
        flush = 1'b1;
        #1;
        n_checks++;
        if ({bus.hit_ready, bus.rep_req_ready, bus.plru_rep_valid} !== 3'b000)
            $display("FAIL flush_ready: got hr=%b rr=%b rv=%b expected 000",
                     bus.hit_ready, bus.rep_req_ready, bus.plru_rep_valid);
        else n_pass++;
        tick();                                   // T5
        flush = 1'b0;
        bus.hit_valid = 1'b0; bus.rep_req_valid = 1'b0;
        wr0 = wr_log.size();
        rd0 = rd_cnt;
        #1;
        n_checks++;
        if ({bus.plru_hit_valid, bus.plru_rep_valid, bus.rep_rsp_valid, bus.rep_req_ready, bus.hit_ready}
            !== 5'b00011)
            $display("FAIL flush_after: got %b expected 00011",
                     {bus.plru_hit_valid, bus.plru_rep_valid, bus.rep_rsp_valid, bus.rep_req_ready, bus.hit_ready});
        else n_pass++;
        repeat (4) tick();
        n_checks++;
        if ({wr_log.size() - wr0, rd_cnt - rd0} !== {32'd0, 32'd0})
            $display("FAIL flush_quiet: got writes=%0d reads=%0d expected 0 0", wr_log.size() - wr0, rd_cnt - rd0);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_reset_mid_lookup();
        int rd0;
        rd0 = rd_cnt;
        tick();
        bus.rep_req_valid = 1'b1; bus.rep_req_index = 6'd40; bus.rep_rsp_ready = 1'b1;
        tick();                                   // LOOKUP: abort with async reset
        bus.rep_req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.plru_rep_valid !== 1'b0) $display("FAIL rst_abort_read: got %b expected 0", bus.plru_rep_valid);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({bus.rep_rsp_valid, rd_cnt - rd0} !== {1'b0, 32'd0})
            $display("FAIL rst_abort_rsp: got v=%b reads=%0d expected 0 0", bus.rep_rsp_valid, rd_cnt - rd0);
        else n_pass++;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_hit();
        test_back_to_back();
        repeat (2) tick();
        test_hazard();
        repeat (2) tick();
        test_resp_hold();
        repeat (2) tick();
        test_flush();
        test_reset_mid_lookup();
        n_checks++;
        if (both_cnt !== 0) $display("FAIL port_exclusive: got %0d overlap cycles expected 0", both_cnt);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
